// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the instruction loader: FSM encoding,
// HALT word and bytes-per-word helper.
package instruction_loader_pkg;

    localparam int unsigned DEF_CANT_BITS_INSTRUCTION = 32;
    localparam int unsigned DEF_CANT_BITS_BYTE        = 8;
    localparam int unsigned DEF_CANT_BITS_ADDRESS     = 10;

    localparam logic [31:0] HALT_WORD = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RECEIVE = 3'd1,
        WRITE   = 3'd2,
        DONE    = 3'd3,
        ERROR   = 3'd4
    } state_t;

    function automatic int unsigned bytes_per_word(int unsigned instr_bits, int unsigned byte_bits);
        return instr_bits / byte_bits;
    endfunction

    localparam int unsigned BYTES_PER_WORD =
        bytes_per_word(DEF_CANT_BITS_INSTRUCTION, DEF_CANT_BITS_BYTE);

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream in / instruction-memory write out bundle of the loader.
interface instruction_loader_if #(
    parameter int unsigned CANT_BITS_INSTRUCTION = 32,
    parameter int unsigned CANT_BITS_BYTE        = 8,
    parameter int unsigned CANT_BITS_ADDRESS     = 10
);
    logic                             i_start;
    logic                             i_data_valid;
    logic [CANT_BITS_BYTE-1:0]        i_data;
    logic                             o_write_enable;
    logic [CANT_BITS_ADDRESS-1:0]     o_address;
    logic [CANT_BITS_INSTRUCTION-1:0] o_instruction;
    logic                             o_busy;
    logic                             o_done;
    logic                             o_error;
    logic [CANT_BITS_ADDRESS:0]       o_instruction_count;

    modport master (
        output i_start, i_data_valid, i_data,
        input  o_write_enable, o_address, o_instruction,
        input  o_busy, o_done, o_error, o_instruction_count
    );

    modport slave (
        input  i_start, i_data_valid, i_data,
        output o_write_enable, o_address, o_instruction,
        output o_busy, o_done, o_error, o_instruction_count
    );
endinterface

// File: rtl/instruction_loader_byte_packer.sv
// Shifts incoming bytes MSB-first into a word; word/word_complete show the
// value including the byte being shifted this cycle.
module instruction_loader_byte_packer
    import instruction_loader_pkg::*;
#(
    parameter int unsigned CANT_BITS_INSTRUCTION = 32,
    parameter int unsigned CANT_BITS_BYTE        = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    input  logic                             shift_en,
    input  logic [CANT_BITS_BYTE-1:0]        data_byte,
    output logic [CANT_BITS_INSTRUCTION-1:0] word,
    output logic                             word_complete
);
    localparam int unsigned BPW = bytes_per_word(CANT_BITS_INSTRUCTION, CANT_BITS_BYTE);
    localparam int unsigned CW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int unsigned LOW = CANT_BITS_INSTRUCTION - CANT_BITS_BYTE;

    logic [CANT_BITS_INSTRUCTION-1:0] shift_q;
    logic [CW-1:0]                    count_q;

    always_comb begin
        word          = shift_q;
        word_complete = 1'b0;
        if (shift_en) begin
            word          = {shift_q[LOW-1:0], data_byte};
            word_complete = (count_q == CW'(BPW - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            count_q <= '0;
        end else if (clear) begin
            shift_q <= '0;
            count_q <= '0;
        end else if (shift_en) begin
            shift_q <= word;
            count_q <= word_complete ? '0 : count_q + CW'(1);
        end
    end
endmodule

// File: rtl/instruction_loader.sv
// Loads a program into instruction memory from a byte stream: packs bytes
// into words, writes them at consecutive addresses until the HALT word.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int unsigned CANT_BITS_INSTRUCTION = 32,
    parameter int unsigned CANT_BITS_BYTE        = 8,
    parameter int unsigned CANT_BITS_ADDRESS     = 10
) (
    input  logic                 i_clock,
    input  logic                 i_soft_reset,
    instruction_loader_if.slave  bus
);
    localparam int unsigned CNT_W = CANT_BITS_ADDRESS + 1;

    state_t                           state_q;
    logic [CANT_BITS_ADDRESS-1:0]     ptr_q;
    logic                             we_q;
    logic [CANT_BITS_ADDRESS-1:0]     addr_q;
    logic [CANT_BITS_INSTRUCTION-1:0] instr_q;
    logic                             busy_q;
    logic                             done_q;
    logic                             error_q;
    logic [CNT_W-1:0]                 count_q;

    logic                             clear_c;
    logic                             shift_en_c;
    logic                             write_ends_c;
    logic [CANT_BITS_INSTRUCTION-1:0] word_c;
    logic                             word_complete_c;

    // A write that ends the session must not let a trailing byte start a new word.
    always_comb begin
        write_ends_c = (instr_q == CANT_BITS_INSTRUCTION'(HALT_WORD)) || (ptr_q == '1);
        clear_c      = (state_q == IDLE) && bus.i_start;
        shift_en_c   = bus.i_data_valid &&
                       ((state_q == RECEIVE) || ((state_q == WRITE) && !write_ends_c));
    end

    instruction_loader_byte_packer #(
        .CANT_BITS_INSTRUCTION (CANT_BITS_INSTRUCTION),
        .CANT_BITS_BYTE        (CANT_BITS_BYTE)
    ) u_byte_packer (
        .clk           (i_clock),
        .rst_n         (i_soft_reset),
        .clear         (clear_c),
        .shift_en      (shift_en_c),
        .data_byte     (bus.i_data),
        .word          (word_c),
        .word_complete (word_complete_c)
    );

    always_ff @(posedge i_clock or negedge i_soft_reset) begin
        if (!i_soft_reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            instr_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            count_q <= '0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.i_start) begin
                        ptr_q   <= '0;
                        error_q <= 1'b0;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RECEIVE;
                    end
                end
                RECEIVE: begin
                    if (word_complete_c) begin
                        we_q    <= 1'b1;
                        addr_q  <= ptr_q;
                        instr_q <= word_c;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    if (instr_q == CANT_BITS_INSTRUCTION'(HALT_WORD)) begin
                        count_q <= CNT_W'(ptr_q) + CNT_W'(1);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else if (ptr_q == '1) begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ERROR;
                    end else begin
                        ptr_q   <= ptr_q + CANT_BITS_ADDRESS'(1);
                        state_q <= RECEIVE;
                    end
                end
                DONE:    state_q <= IDLE;
                ERROR:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_write_enable      = we_q;
    assign bus.o_address           = addr_q;
    assign bus.o_instruction       = instr_q;
    assign bus.o_busy              = busy_q;
    assign bus.o_done              = done_q;
    assign bus.o_error             = error_q;
    assign bus.o_instruction_count = count_q;
endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: a per-cycle vector table for a
// streamed program plus hand-written sessions for the corner cases.
module tb_instruction_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic st = 1'b0, vl = 1'b0, sel = 1'b0;
    logic [7:0] dt = 8'h00;

    int n_vec = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    instruction_loader_if #(.CANT_BITS_ADDRESS(10)) bus ();
    instruction_loader_if #(.CANT_BITS_ADDRESS(2))  bus2 ();

    assign bus.i_start       = st & ~sel;
    assign bus.i_data_valid  = vl & ~sel;
    assign bus.i_data        = dt;
    assign bus2.i_start      = st & sel;
    assign bus2.i_data_valid = vl & sel;
    assign bus2.i_data       = dt;

    instruction_loader #(.CANT_BITS_INSTRUCTION(32), .CANT_BITS_BYTE(8), .CANT_BITS_ADDRESS(10)) dut (
        .i_clock(clk), .i_soft_reset(rst_n), .bus(bus.slave));
    instruction_loader #(.CANT_BITS_INSTRUCTION(32), .CANT_BITS_BYTE(8), .CANT_BITS_ADDRESS(2)) dut2 (
        .i_clock(clk), .i_soft_reset(rst_n), .bus(bus2.slave));

    // Write/done monitors for both instances
    logic [41:0] wq[$];
    logic [33:0] wq2[$];
    int done_cnt = 0;
    int done2_cnt = 0;
    always @(negedge clk) begin
        if (bus.o_write_enable)  wq.push_back({bus.o_address, bus.o_instruction});
        if (bus2.o_write_enable) wq2.push_back({bus2.o_address, bus2.o_instruction});
        if (bus.o_done)  done_cnt++;
        if (bus2.o_done) done2_cnt++;
    end

    typedef struct {
        logic        s;
        logic        v;
        logic [7:0]  d;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] instr;
        logic        busy;
        logic        done;
        logic [10:0] cnt;
    } vec_t;

    function automatic vec_t mk(logic s, logic v, logic [7:0] d, logic we, logic [9:0] a,
                                logic [31:0] ins, logic busy, logic done, logic [10:0] cnt);
        vec_t r;
        r.s = s; r.v = v; r.d = d; r.we = we; r.addr = a;
        r.instr = ins; r.busy = busy; r.done = done; r.cnt = cnt;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_wq(input string name, input int idx, input logic [41:0] exp);
        logic [41:0] act;
        act = (idx < wq.size()) ? wq[idx] : '1;
        check(name, 64'(act), 64'(exp));
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk); vl = 1'b1; dt = b;
        @(negedge clk); vl = 1'b0; dt = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] t;
        t = w;
        for (int i = 3; i >= 0; i--) send_byte(t[i*8 +: 8]);
    endtask

    task automatic pulse_start();
        @(negedge clk); st = 1'b1;
        @(negedge clk); st = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [63:0] outs1();
        return 64'({bus.o_write_enable, bus.o_address, bus.o_instruction, bus.o_busy,
                    bus.o_done, bus.o_error, bus.o_instruction_count});
    endfunction

    vec_t tbl[15];

    initial begin
        // Streamed program, one byte per cycle; outputs checked after each edge
        tbl[0]  = mk(1, 0, 8'h00, 0, 10'd0, 32'h0000_0000, 1, 0, 11'd0);
        tbl[1]  = mk(0, 1, 8'h00, 0, 10'd0, 32'h0000_0000, 1, 0, 11'd0);
        tbl[2]  = mk(0, 1, 8'h22, 0, 10'd0, 32'h0000_0000, 1, 0, 11'd0);
        tbl[3]  = mk(0, 1, 8'h18, 0, 10'd0, 32'h0000_0000, 1, 0, 11'd0);
        tbl[4]  = mk(0, 1, 8'h04, 1, 10'd0, 32'h0022_1804, 1, 0, 11'd0);
        tbl[5]  = mk(0, 1, 8'h02, 0, 10'd0, 32'h0022_1804, 1, 0, 11'd0);
        tbl[6]  = mk(0, 1, 8'h80, 0, 10'd0, 32'h0022_1804, 1, 0, 11'd0);
        tbl[7]  = mk(0, 1, 8'h00, 0, 10'd0, 32'h0022_1804, 1, 0, 11'd0);
        tbl[8]  = mk(0, 1, 8'h08, 1, 10'd1, 32'h0280_0008, 1, 0, 11'd0);
        tbl[9]  = mk(0, 1, 8'h00, 0, 10'd1, 32'h0280_0008, 1, 0, 11'd0);
        tbl[10] = mk(0, 1, 8'h00, 0, 10'd1, 32'h0280_0008, 1, 0, 11'd0);
        tbl[11] = mk(0, 1, 8'h00, 0, 10'd1, 32'h0280_0008, 1, 0, 11'd0);
        tbl[12] = mk(0, 1, 8'h00, 1, 10'd2, 32'h0000_0000, 1, 0, 11'd0);
        tbl[13] = mk(0, 0, 8'h00, 0, 10'd2, 32'h0000_0000, 0, 1, 11'd3);
        tbl[14] = mk(0, 0, 8'h00, 0, 10'd2, 32'h0000_0000, 0, 0, 11'd3);

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", outs1(), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // 1: two-word program ending in HALT
        wq.delete();
        pulse_start();
        send_word(32'h0001_10C0);
        send_word(32'h0000_0000);
        idle(5);
        check("t1_nwrites", 64'(wq.size()), 64'd2);
        check_wq("t1_write0", 0, {10'd0, 32'h0001_10C0});
        check_wq("t1_write1", 1, {10'd1, 32'h0000_0000});
        check("t1_done_pulses", 64'(done_cnt), 64'd1);
        check("t1_count_busy", 64'({bus.o_instruction_count, bus.o_busy}), 64'({11'd2, 1'b0}));

        // 2: bytes ignored in IDLE, then a HALT-only program
        wq.delete();
        for (int i = 0; i < 8; i++) send_byte(8'hFF);
        check("t2_idle_no_write", 64'(wq.size()), 64'd0);
        pulse_start();
        send_word(32'h0000_0000);
        idle(5);
        check("t2_nwrites", 64'(wq.size()), 64'd1);
        check_wq("t2_write0", 0, {10'd0, 32'h0000_0000});
        check("t2_count", 64'(bus.o_instruction_count), 64'd1);

        // 3: back-to-back bytes, per-cycle vector table
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            st = tbl[i].s; vl = tbl[i].v; dt = tbl[i].d;
            @(posedge clk);
            #1;
            check($sformatf("t3_vec%0d", i), outs1(),
                  64'({tbl[i].we, tbl[i].addr, tbl[i].instr, tbl[i].busy, tbl[i].done,
                       1'b0, tbl[i].cnt}));
        end
        @(negedge clk); st = 1'b0; vl = 1'b0; dt = 8'h00;

        // 4: 2-bit address instance fills memory without HALT
        sel = 1'b1;
        wq2.delete();
        pulse_start();
        for (int i = 0; i < 4; i++) send_word(32'h0800_0007);
        idle(5);
        check("t4_nwrites", 64'(wq2.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t4_write%0d", i), 64'((i < wq2.size()) ? wq2[i] : '1),
                  64'({2'(i), 32'h0800_0007}));
        check("t4_error_no_done", 64'({bus2.o_error, bus2.o_busy, 8'(done2_cnt)}),
              64'({1'b1, 1'b0, 8'd0}));
        pulse_start();
        check("t4_error_cleared", 64'({bus2.o_error, bus2.o_busy}), 64'({1'b0, 1'b1}));
        sel = 1'b0;

        // 5: reset mid-word aborts the session
        wq.delete();
        pulse_start();
        send_byte(8'h55);
        send_byte(8'h66);
        #2 rst_n = 1'b0;
        #1 check("t5_async_reset", outs1(), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        pulse_start();
        send_word(32'h82A1_0008);
        send_word(32'h0000_0000);
        idle(5);
        check("t5_nwrites", 64'(wq.size()), 64'd2);
        check_wq("t5_write0", 0, {10'd0, 32'h82A1_0008});
        check_wq("t5_write1", 1, {10'd1, 32'h0000_0000});

        // 6: start during RECEIVE is ignored
        wq.delete();
        pulse_start();
        send_byte(8'h11);
        pulse_start();
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_word(32'h0000_0000);
        idle(5);
        check("t6_nwrites", 64'(wq.size()), 64'd2);
        check_wq("t6_write0", 0, {10'd0, 32'h1122_3344});
        check("t6_count", 64'(bus.o_instruction_count), 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/instruction_loader.md
# instruction_loader

Loads a MIPS program into instruction memory from a byte stream (debug-unit UART receiver). Packs four bytes, most-significant first, into one 32-bit instruction and writes it at consecutive word addresses from 0. Loading stops when the all-zero HALT word has been written; the instruction fetch and control path then execute the program. This block is the writer of the instruction memory that the fetch stage and `control` read.

## Interface
Parameters:
- `CANT_BITS_INSTRUCTION`, 32, instruction width; must be a multiple of `CANT_BITS_BYTE`.
- `CANT_BITS_BYTE`, 8, width of an incoming data byte.
- `CANT_BITS_ADDRESS`, 10, instruction-memory word-address width.

Ports:
- `i_clock`  in  1  system clock, rising edge.
- `i_soft_reset`  in  1  reset, asynchronous, active-low.
- `i_start`  in  1  one-cycle pulse that opens a load session.
- `i_data_valid`  in  1  one-cycle strobe: `i_data` holds a new byte.
- `i_data`  in  `CANT_BITS_BYTE`  received byte.
- `o_write_enable`  out  1  instruction-memory write strobe.
- `o_address`  out  `CANT_BITS_ADDRESS`  word address for the write.
- `o_instruction`  out  `CANT_BITS_INSTRUCTION`  assembled word.
- `o_busy`  out  1  high while a session is active.
- `o_done`  out  1  one-cycle pulse after the HALT word is written.
- `o_error`  out  1  sticky; memory filled without a HALT word.
- `o_instruction_count`  out  `CANT_BITS_ADDRESS`+1  words written, including HALT.

## Operation
- FSM states: IDLE, RECEIVE, WRITE, DONE, ERROR.
- IDLE:
  - `i_data_valid` is ignored.
  - `i_start` clears the address pointer, byte counter, `o_error` and `o_instruction_count`, then moves to RECEIVE.
- RECEIVE:
  - Each valid byte shifts into the packing register. Byte 0 lands in [31:24], byte 3 in [7:0].
  - The 2-bit byte counter increments per byte.
  - On the 4th byte the FSM moves to WRITE.
- WRITE (one cycle):
  - `o_write_enable`=1, `o_address`=pointer, `o_instruction`=packed word.
  - Word == 32'h0 (HALT): `o_instruction_count` = pointer+1, go to DONE.
  - Pointer == 2^`CANT_BITS_ADDRESS`−1 and word is not HALT: go to ERROR.
  - Otherwise: pointer+1, go to RECEIVE.
  - A valid byte arriving in WRITE becomes byte 0 of the next word (byte counter = 1), except when the next state is DONE or ERROR; then it is dropped.
- DONE: `o_done`=1 for one cycle, then IDLE.
- ERROR:
  - `o_error`=1, then IDLE. `o_error` stays high until the next `i_start` or reset.
- `i_start` outside IDLE is ignored.
- `o_busy` = 1 in RECEIVE and WRITE only.

## Timing
- Reset values:
  - All outputs are 0.
  - Pointer, byte counter and packing register are 0.
  - State is IDLE.
- Reset asserted mid-session aborts the session immediately. Partial bytes are discarded and no write is issued.
- All outputs are registered.
- `o_write_enable` rises the cycle after the 4th byte is accepted.
- `o_done` rises the cycle after the HALT write.
- `o_instruction_count` is valid from `o_done` until the next `i_start`.
- Back-to-back valid bytes every cycle are accepted with no loss.
- `o_address` and `o_instruction` hold their last values outside WRITE.

## Structure
- Shared package:
  - FSM state encoding.
  - HALT constant (32'h0).
  - Bytes-per-word constant (`CANT_BITS_INSTRUCTION`/`CANT_BITS_BYTE`).
- One sub-module, `byte_packer`:
  - Shift register plus byte counter.
  - Inputs: clear, shift-enable, byte.
  - Outputs: word, word_complete.
- The FSM, pointer and outputs stay in `instruction_loader`.

## Test plan
1. Reset, release, `i_start`, send 00 01 10 C0 then 00 00 00 00 -> write addr 0 = 0x000110C0, write addr 1 = 0x00000000, `o_done` pulse, `o_instruction_count`=2, `o_busy`=0.
2. Bytes 0xFF ×8 with `i_data_valid` while IDLE -> no `o_write_enable`. Then `i_start` + 4 zero bytes -> single write addr 0 = 0x0, count=1.
3. `i_start`, bytes streamed one per cycle: 00 22 18 04, 02 80 00 08, 00 00 00 00 -> writes 0x00221804@0, 0x02800008@1, 0x0@2, no byte lost, count=3.
4. `CANT_BITS_ADDRESS`=2, four non-zero words (e.g. 0x08000007) -> four writes at addresses 0..3, then `o_error`=1, no `o_done`. Next `i_start` -> `o_error`=0.
5. Send 2 bytes, assert `i_soft_reset`=0 -> all outputs 0 asynchronously. Release, `i_start`, send 82 A1 00 08 then HALT -> addr 0 = 0x82A10008, no leftover bytes.
6. `i_start` pulsed during RECEIVE after 1 byte -> ignored. Remaining 3 bytes complete the word at addr 0 unchanged.
